// File: rtl/video_sync_decoder.sv
// Composite sync decoder: measures sync-tip widths, classifies them into
// equalising / line / broad pulses, and derives line/pixel timing plus lock.
module video_sync_decoder #(
    parameter int GLITCH_MAX  = 15,
    parameter int EQ_MAX      = 40,
    parameter int H_MAX       = 100,
    parameter int BROAD_MIN   = 200,
    parameter int TIMEOUT     = 1000,
    parameter int LOCK_PULSES = 4
) (
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic       i_sync,
    input  logic       i_white,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic [9:0] o_line,
    output logic [9:0] o_pixel,
    output logic       o_white,
    output logic       o_locked
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int LW = $clog2(LOCK_PULSES + 1);

    localparam logic [8:0]    GLITCH_W  = 9'(GLITCH_MAX);
    localparam logic [8:0]    EQ_W      = 9'(EQ_MAX);
    localparam logic [8:0]    H_W       = 9'(H_MAX);
    localparam logic [8:0]    BROAD_W   = 9'(BROAD_MIN);
    localparam logic [TW-1:0] TIMEOUT_W = TW'(TIMEOUT);
    localparam logic [LW-1:0] LOCK_W    = LW'(LOCK_PULSES);

    typedef enum logic [1:0] {WAIT_HIGH, HIGH, LOW} pulse_state_t;
    typedef enum logic {UNLOCKED, LOCKED} lock_state_t;
    typedef enum logic [2:0] {
        CLS_NONE, CLS_GLITCH, CLS_EQ, CLS_LINE, CLS_INVALID, CLS_BROAD
    } pulse_class_t;

    logic          sync_m, sync_s, white_m, white_s;
    pulse_state_t  pulse_state;
    lock_state_t   lock_state;
    logic [8:0]    width;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_inc;
    logic [LW-1:0] lock_cnt;
    logic          prev_broad;
    pulse_class_t  cls;
    logic          valid;
    logic          invalid;
    logic          timeout_hit;

    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        cls = CLS_NONE;
        if (pulse_state == LOW && sync_s) begin
            if (width <= GLITCH_W)     cls = CLS_GLITCH;
            else if (width <= EQ_W)    cls = CLS_EQ;
            else if (width <= H_W)     cls = CLS_LINE;
            else if (width < BROAD_W)  cls = CLS_INVALID;
            else                       cls = CLS_BROAD;
        end
    end

    assign valid       = (cls == CLS_EQ) || (cls == CLS_LINE) || (cls == CLS_BROAD);
    assign invalid     = (cls == CLS_INVALID);
    assign tcnt_inc    = (tcnt == TIMEOUT_W) ? tcnt : tcnt + 1'b1;
    assign timeout_hit = (tcnt_inc == TIMEOUT_W);
    assign o_locked    = (lock_state == LOCKED);

    // NOTE: all state here uses non-blocking assignments so every flop samples pre-edge values, as real hardware does.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_m      <= 1'b0;
            sync_s      <= 1'b0;
            white_m     <= 1'b0;
            white_s     <= 1'b0;
            o_white     <= 1'b0;
            o_hsync     <= 1'b0;
            o_vsync     <= 1'b0;
            o_line      <= '0;
            o_pixel     <= '0;
            pulse_state <= WAIT_HIGH;
            lock_state  <= UNLOCKED;
            width       <= '0;
            tcnt        <= '0;
            lock_cnt    <= '0;
            prev_broad  <= 1'b0;
        end else begin
            sync_m  <= i_sync;
            sync_s  <= sync_m;
            white_m <= i_white;
            white_s <= white_m;
            o_white <= white_s & sync_s;
            o_hsync <= (cls == CLS_LINE);
            o_vsync <= (cls == CLS_BROAD) && !prev_broad;

            // A low level seen in WAIT_HIGH has no known start, so it is never measured.
            case (pulse_state)
                WAIT_HIGH: if (sync_s) pulse_state <= HIGH;
                HIGH: begin
                    if (!sync_s) begin
                        pulse_state <= LOW;
                        width       <= 9'd1;
                    end
                end
                LOW: begin
                    if (sync_s)           pulse_state <= HIGH;
                    else if (width != '1) width <= width + 1'b1;
                end
                default: pulse_state <= WAIT_HIGH;
            endcase

            if (valid || invalid) prev_broad <= (cls == CLS_BROAD);

            if (cls == CLS_BROAD && !prev_broad) o_line <= '0;
            else if (cls == CLS_LINE && o_line != '1) o_line <= o_line + 1'b1;

            if (valid || invalid)  o_pixel <= '0;
            else if (o_pixel != '1) o_pixel <= o_pixel + 1'b1;

            tcnt <= valid ? '0 : tcnt_inc;

            // A classification in the timeout cycle wins, so valid is tested before timeout_hit.
            if (invalid) begin
                lock_cnt   <= '0;
                lock_state <= UNLOCKED;
            end else if (valid) begin
                if (lock_cnt != LOCK_W) lock_cnt <= lock_cnt + 1'b1;
                if (lock_cnt >= LOCK_W - 1'b1) lock_state <= LOCKED;
            end else if (timeout_hit) begin
                lock_cnt   <= '0;
                lock_state <= UNLOCKED;
            end
        end
    end

endmodule

// File: tb/tb_video_sync_decoder.sv
// Directed bench for video_sync_decoder: line/field sync, width boundaries,
// timeout, white gating and reset during a pulse.
`timescale 1ns/1ps
module tb_video_sync_decoder;

    logic       clk = 1'b0;
    logic       i_rst_n;
    logic       i_sync;
    logic       i_white;
    logic       o_hsync;
    logic       o_vsync;
    logic [9:0] o_line;
    logic [9:0] o_pixel;
    logic       o_white;
    logic       o_locked;

    int n_tests = 0;
    int n_fail  = 0;
    int hs_cnt  = 0;
    int vs_cnt  = 0;
    int hs0;
    int vs0;

    always #5 clk = ~clk;

    video_sync_decoder dut (
        .clk      (clk),
        .i_rst_n  (i_rst_n),
        .i_sync   (i_sync),
        .i_white  (i_white),
        .o_hsync  (o_hsync),
        .o_vsync  (o_vsync),
        .o_line   (o_line),
        .o_pixel  (o_pixel),
        .o_white  (o_white),
        .o_locked (o_locked)
    );

    always @(negedge clk) begin
        if (o_hsync) hs_cnt++;
        if (o_vsync) vs_cnt++;
    end

    task automatic check(input string tag, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Low for lo clocks, then high for hi clocks; starts and ends on a falling clock edge.
    task automatic send_pulse(input int lo, input int hi);
        i_sync = 1'b0;
        repeat (lo) @(negedge clk);
        i_sync = 1'b1;
        repeat (hi) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst_n = 1'b0;
        i_sync  = 1'b1;
        i_white = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hsync",  int'(o_hsync),  0);
        check("rst_vsync",  int'(o_vsync),  0);
        check("rst_line",   int'(o_line),   0);
        check("rst_pixel",  int'(o_pixel),  0);
        check("rst_white",  int'(o_white),  0);
        check("rst_locked", int'(o_locked), 0);
        i_rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Line sync: first pulse checked for exact latency.
        hs0 = hs_cnt;
        i_sync = 1'b0;
        repeat (56) @(negedge clk);
        i_sync = 1'b1;
        repeat (2) @(negedge clk);
        check("hsync_lat2", int'(o_hsync), 0);
        @(negedge clk);
        check("hsync_lat3", int'(o_hsync), 1);
        check("pixel_clr",  int'(o_pixel), 0);
        @(negedge clk);
        check("hsync_lat4", int'(o_hsync), 0);
        check("pixel_inc",  int'(o_pixel), 1);
        repeat (712 - 4) @(negedge clk);
        check("line_1", int'(o_line), 1);
        for (int i = 2; i <= 6; i++) begin
            send_pulse(56, 712);
            check($sformatf("line_%0d", i), int'(o_line), i);
            if (i == 3) check("lock_after3", int'(o_locked), 0);
            if (i == 4) check("lock_after4", int'(o_locked), 1);
        end
        check("hsync_count6", hs_cnt - hs0, 6);

        // Field sync: five broad pulses at half-line spacing, then line syncs.
        vs0 = vs_cnt;
        repeat (5) send_pulse(328, 56);
        check("field_vsync_once", vs_cnt - vs0, 1);
        check("field_line0",      int'(o_line), 0);
        check("field_locked",     int'(o_locked), 1);
        for (int i = 1; i <= 3; i++) begin
            send_pulse(56, 712);
            check($sformatf("field_line%0d", i), int'(o_line), i);
        end

        // Width boundaries.
        hs0 = hs_cnt;
        send_pulse(16, 300);
        check("eq16_line",  int'(o_line), 3);
        check("eq16_pixel", int'(o_pixel), 297);
        check("eq16_hs",    hs_cnt - hs0, 0);
        send_pulse(15, 300);
        check("gl15_pixel",  int'(o_pixel), 612);
        check("gl15_line",   int'(o_line), 3);
        check("gl15_locked", int'(o_locked), 1);
        send_pulse(40, 300);
        check("eq40_pixel", int'(o_pixel), 297);
        check("eq40_line",  int'(o_line), 3);
        check("eq40_hs",    hs_cnt - hs0, 0);
        send_pulse(41, 300);
        check("ln41_line", int'(o_line), 4);
        check("ln41_hs",   hs_cnt - hs0, 1);
        send_pulse(100, 300);
        check("ln100_line", int'(o_line), 5);
        check("ln100_hs",   hs_cnt - hs0, 2);
        send_pulse(101, 300);
        check("inv101_locked", int'(o_locked), 0);
        check("inv101_line",   int'(o_line), 5);
        check("inv101_pixel",  int'(o_pixel), 297);
        check("inv101_hs",     hs_cnt - hs0, 2);
        for (int i = 1; i <= 4; i++) begin
            send_pulse(56, 300);
            if (i == 3) check("relock3", int'(o_locked), 0);
        end
        check("relock4",      int'(o_locked), 1);
        check("relock_line9", int'(o_line), 9);
        send_pulse(199, 300);
        check("inv199_locked", int'(o_locked), 0);
        check("inv199_line",   int'(o_line), 9);
        vs0 = vs_cnt;
        send_pulse(200, 300);
        check("br200_vsync", vs_cnt - vs0, 1);
        check("br200_line",  int'(o_line), 0);

        // Timeout: relock, then hold sync high.
        send_pulse(56, 300);
        send_pulse(56, 300);
        check("to_prelock2", int'(o_locked), 0);
        send_pulse(56, 300);
        check("to_lock3", int'(o_locked), 1);
        hs0 = hs_cnt;
        repeat (702) @(negedge clk);
        check("to_locked_999", int'(o_locked), 1);
        @(negedge clk);
        check("to_locked_1000", int'(o_locked), 0);
        check("to_pixel_1000",  int'(o_pixel), 1000);
        repeat (30) @(negedge clk);
        check("to_pixel_sat", int'(o_pixel), 1023);
        check("to_no_hsync",  hs_cnt - hs0, 0);
        check("to_line",      int'(o_line), 3);

        // White gating through a line sync, decoded while unlocked.
        i_white = 1'b1;
        repeat (5) @(negedge clk);
        check("white_pre", int'(o_white), 1);
        hs0 = hs_cnt;
        i_sync = 1'b0;
        repeat (2) @(negedge clk);
        check("white_fall2", int'(o_white), 1);
        @(negedge clk);
        check("white_fall3", int'(o_white), 0);
        repeat (53) @(negedge clk);
        i_sync = 1'b1;
        repeat (2) @(negedge clk);
        check("white_rise2", int'(o_white), 0);
        @(negedge clk);
        check("white_rise3", int'(o_white), 1);
        repeat (297) @(negedge clk);
        check("unlocked_hsync",  hs_cnt - hs0, 1);
        check("unlocked_locked", int'(o_locked), 0);
        check("unlocked_line",   int'(o_line), 4);

        // Reset asserted and released during a low pulse.
        i_sync = 1'b0;
        repeat (20) @(negedge clk);
        i_rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_line",   int'(o_line), 0);
        check("midrst_locked", int'(o_locked), 0);
        i_rst_n = 1'b1;
        repeat (31) @(negedge clk);
        hs0 = hs_cnt;
        i_sync = 1'b1;
        repeat (300) @(negedge clk);
        check("midrst_abort_hs",   hs_cnt - hs0, 0);
        check("midrst_abort_line", int'(o_line), 0);
        send_pulse(56, 300);
        check("midrst_next_hs",   hs_cnt - hs0, 1);
        check("midrst_next_line", int'(o_line), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/video_sync_decoder.md
VIDEO_SYNC_DECODER -- requirements
Module: video_sync_decoder

Interface
REQ-001 Parameter GLITCH_MAX, default 15: low pulses of at most this many clocks are ignored.
REQ-002 Parameter EQ_MAX, default 40: low pulses of GLITCH_MAX+1..EQ_MAX clocks classify as equalising.
REQ-003 Parameter H_MAX, default 100: low pulses of EQ_MAX+1..H_MAX clocks classify as line sync.
REQ-004 Parameter BROAD_MIN, default 200: low pulses of at least BROAD_MIN clocks classify as broad (field sync).
REQ-005 Parameter TIMEOUT, default 1000: clocks without a classified pulse before lock is lost.
REQ-006 Parameter LOCK_PULSES, default 4: consecutive classified pulses needed to assert lock.
REQ-007 clk  input  1  system clock, 12 MHz nominal.
REQ-008 i_rst_n  input  1  asynchronous, active-low reset.
REQ-009 i_sync  input  1  composite sync level; 0 = sync tip, 1 = black/picture; asynchronous to clk.
REQ-010 i_white  input  1  luminance bit; 1 = white; asynchronous to clk.
REQ-011 o_hsync  output  1  one-clock pulse on each line-sync classification.
REQ-012 o_vsync  output  1  one-clock pulse on the first broad pulse of a field.
REQ-013 o_line  output  10  line count within the field.
REQ-014 o_pixel  output  10  clocks since the end of the last line sync.
REQ-015 o_white  output  1  synchronised i_white, gated by synchronised i_sync.
REQ-016 o_locked  output  1  1 while the decoder tracks valid sync.

Function
REQ-017 i_sync and i_white SHALL each pass through a two-flop synchroniser; all later timing refers to the synchronised signals (sync_s, white_s).
REQ-018 The pulse FSM SHALL have three states: WAIT_HIGH, HIGH and LOW.
REQ-019 WAIT_HIGH -> HIGH when sync_s = 1; low periods seen in WAIT_HIGH are never measured.
REQ-020 HIGH -> LOW on sync_s = 0; the 9-bit width counter loads 1.
REQ-021 In LOW, the width counter SHALL increment each clock and saturate at 511.
REQ-022 LOW -> HIGH on sync_s = 1; the pulse SHALL be classified from the width counter in that same cycle.
REQ-023 Widths H_MAX+1..BROAD_MIN-1 SHALL classify as invalid: the pulse is not counted and the lock pulse counter clears.
REQ-024 Glitches (width <= GLITCH_MAX) SHALL affect no counter, output or lock state.
REQ-025 o_hsync SHALL pulse in the cycle after a line-sync classification, which is 3 clocks after the i_sync rising edge.
REQ-026 On line sync, o_line SHALL increment and saturate at 1023.
REQ-027 A broad pulse classified when the previous classified pulse was not broad SHALL pulse o_vsync and set o_line to 0; further consecutive broad pulses SHALL change neither.
REQ-028 Equalising pulses SHALL leave o_line unchanged.
REQ-029 o_pixel SHALL clear to 0 on any non-glitch classification, increment each clock otherwise, and saturate at 1023.
REQ-030 o_white SHALL equal white_s AND sync_s, registered, so it is forced to 0 during sync.
REQ-031 The timeout counter SHALL clear on any non-glitch, non-invalid classification, increment otherwise, and saturate at TIMEOUT.
REQ-032 The lock FSM SHALL have two states: UNLOCKED and LOCKED.
REQ-033 UNLOCKED -> LOCKED after LOCK_PULSES consecutive valid classifications (equalising, line or broad).
REQ-034 LOCKED -> UNLOCKED when the timeout counter reaches TIMEOUT or an invalid pulse is classified.
REQ-035 If a classification and a timeout occur in the same cycle, the classification SHALL win: the counter clears and lock is kept.
REQ-036 o_hsync and o_vsync SHALL be produced whether or not o_locked is set.

Reset
REQ-037 While i_rst_n = 0: pulse FSM = WAIT_HIGH, lock FSM = UNLOCKED, all counters = 0, o_hsync = o_vsync = o_white = o_locked = 0, o_line = o_pixel = 0, synchroniser flops = 0.
REQ-038 A reset asserted in the middle of a pulse SHALL abort that pulse; the first low period after release that is not preceded by a high level is never classified.

Verification
REQ-039 Line sync: at 12 MHz, 56-clock low pulses every 768 clocks -> o_hsync each line; o_locked = 1 after the 4th pulse; o_line increments by 1 per pulse.
REQ-040 Field sync: 5 broad pulses of 328 clocks at half-line spacing, then line syncs -> a single o_vsync on the first broad pulse, o_line = 0, then 1, 2, 3 on the following line syncs.
REQ-041 Width boundaries: pulses of 15, 16, 40, 41, 100, 101, 199 and 200 clocks -> classified as glitch, equalising, equalising, line, line, invalid, invalid and broad; each invalid pulse clears lock.
REQ-042 Timeout: while locked, hold i_sync = 1 -> o_locked falls exactly when the timeout counter reaches 1000; o_pixel saturates at 1023.
REQ-043 Reset mid-pulse: assert i_rst_n = 0 during a 56-clock low pulse and release while still low -> no o_hsync for that pulse; the next full pulse is classified normally.
REQ-044 White gating: i_white = 1 held through a sync pulse -> o_white = 0 for the pulse duration plus synchroniser latency, then 1.
